// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbitration blocks.
package uart_ctrl_pkg;

  localparam int unsigned NUM_REQ_DEF       = 4;
  localparam int unsigned START_TIMEOUT_DEF = 16;
  localparam int unsigned GRANT_W           = 3;
  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned CNT_W             = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester after last_grant, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_valid_o
);

  logic [IDX_W-1:0] cand;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
    return (32'(g) == NUM_REQ - 1) ? '0 : g + IDX_W'(1);
  endfunction

  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    cand        = last_grant_i;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = next_idx(cand);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!any_valid_o && req_valid_i[i] && (cand == IDX_W'(i))) begin
          winner_o    = cand;
          any_valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART transmitter: one byte per grant, then
// follows tx_busy through the character (or a start timeout) before regranting.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ       = NUM_REQ_DEF,
  parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [BYTE_W-1:0]           tx_data_o,
  output logic                        tx_begin_o,
  input  logic                        tx_busy_i,
  output logic [GRANT_W-1:0]          grant_id_o,
  output logic                        active_o,
  output logic                        tx_done_o,
  output logic                        timeout_err_o
);

  state_e             state_q, state_d;
  logic [GRANT_W-1:0] last_grant_q, last_grant_d;
  logic [GRANT_W-1:0] grant_id_q, grant_id_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic [CNT_W-1:0]   timeout_cnt_q, timeout_cnt_d;
  logic               tx_begin_q, tx_begin_d;
  logic               active_q, active_d;
  logic               tx_done_q, tx_done_d;
  logic               timeout_err_q, timeout_err_d;

  logic [GRANT_W-1:0] winner;
  logic               any_valid;
  logic               handshake;
  logic               start_expired;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GRANT_W)
  ) u_rr (
    .req_valid_i  (req_valid_i),
    .last_grant_i (last_grant_q),
    .winner_o     (winner),
    .any_valid_o  (any_valid)
  );

  // Another user holding the transmitter in IDLE blocks any grant.
  assign handshake     = (state_q == ST_IDLE) && any_valid && !tx_busy_i;
  assign start_expired = (timeout_cnt_q == CNT_W'(START_TIMEOUT - 1));

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (handshake) state_d = ST_START;
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy_i)          state_d = ST_WAIT_DONE;
        else if (start_expired) state_d = ST_IDLE;
      end
      ST_WAIT_DONE: if (!tx_busy_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    timeout_cnt_d = timeout_cnt_q;
    tx_begin_d    = (state_d == ST_START);
    active_d      = (state_d != ST_IDLE);
    tx_done_d     = 1'b0;
    timeout_err_d = 1'b0;
    req_ready_o   = '0;
    case (state_q)
      ST_IDLE: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (handshake && (winner == GRANT_W'(i))) begin
            req_ready_o[i] = 1'b1;
            tx_data_d      = req_data_i[BYTE_W*i +: BYTE_W];
          end
        end
        if (handshake) begin
          grant_id_d   = winner;
          last_grant_d = winner;
        end
      end
      ST_START:     timeout_cnt_d = '0;
      ST_WAIT_BUSY: begin
        if (!tx_busy_i && start_expired) timeout_err_d = 1'b1;
        else if (!tx_busy_i)             timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
      end
      ST_WAIT_DONE: tx_done_d = !tx_busy_i;
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      last_grant_q  <= GRANT_W'(NUM_REQ - 1);
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      timeout_cnt_q <= '0;
      tx_begin_q    <= 1'b0;
      active_q      <= 1'b0;
      tx_done_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      timeout_cnt_q <= timeout_cnt_d;
      tx_begin_q    <= tx_begin_d;
      active_q      <= active_d;
      tx_done_q     <= tx_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_data_o     = tx_data_q;
  assign tx_begin_o    = tx_begin_q;
  assign grant_id_o    = grant_id_q;
  assign active_o      = active_q;
  assign tx_done_o     = tx_done_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a round-robin reference model.
module tb_uart_tx_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] req_valid;
  logic [31:0] req_data;
  logic [3:0] req_ready;
  logic [7:0] tx_data;
  logic       tx_begin;
  logic       tx_busy;
  logic [2:0] grant_id;
  logic       active;
  logic       tx_done;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int model_last = 3;
  logic [7:0] bytes [4];

  uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(16)) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .tx_data_o     (tx_data),
    .tx_begin_o    (tx_begin),
    .tx_busy_i     (tx_busy),
    .grant_id_o    (grant_id),
    .active_o      (active),
    .tx_done_o     (tx_done),
    .timeout_err_o (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data();
    req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
  endtask

  // Spec rule: first valid index after the previous grant, wrapping modulo 4.
  function automatic int rr_model(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; tx_busy = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_last = 3;
  endtask

  // One full transfer: handshake now, busy one cycle after tx_begin for busy_len cycles.
  task automatic run_byte(input logic [3:0] v, input int busy_len, output int gid);
    int exp;
    logic [3:0] exp_rdy;
    req_valid = v; tx_busy = 1'b0;
    #1;
    exp = rr_model(v, model_last);
    exp_rdy = 4'(1 << exp);
    checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL handshake_ready got=%b exp=%b", req_ready, exp_rdy); end
    tick();
    checks++; if (tx_begin !== 1'b1) begin errors++; $display("FAIL begin_strobe got=%b exp=1", tx_begin); end
    checks++; if (tx_data !== bytes[exp]) begin errors++; $display("FAIL tx_data got=%h exp=%h", tx_data, bytes[exp]); end
    checks++; if (grant_id !== 3'(exp)) begin errors++; $display("FAIL grant_id got=%0d exp=%0d", grant_id, exp); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL ready_outside_idle got=%b exp=0000", req_ready); end
    gid = int'(grant_id);
    tick();
    checks++; if (tx_begin !== 1'b0) begin errors++; $display("FAIL begin_one_cycle got=%b exp=0", tx_begin); end
    tx_busy = 1'b1;
    repeat (busy_len) begin
      tick();
      checks++; if (tx_done !== 1'b0 || active !== 1'b1) begin errors++; $display("FAIL busy_phase done=%b active=%b exp done=0 active=1", tx_done, active); end
    end
    tx_busy = 1'b0;
    tick();
    checks++; if (tx_done !== 1'b1 || active !== 1'b0) begin errors++; $display("FAIL tx_done done=%b active=%b exp done=1 active=0", tx_done, active); end
    checks++; if (tx_data !== bytes[exp]) begin errors++; $display("FAIL tx_data_hold got=%h exp=%h", tx_data, bytes[exp]); end
    model_last = exp;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if ({tx_begin, active, tx_done, timeout_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {tx_begin, active, tx_done, timeout_err}); end
    checks++; if (tx_data !== 8'h00 || grant_id !== 3'd0) begin errors++; $display("FAIL reset_regs data=%h gid=%0d exp 00/0", tx_data, grant_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
  endtask

  task automatic test_single();
    int gid;
    bytes[0] = 8'h41; bytes[1] = 8'h00; bytes[2] = 8'h00; bytes[3] = 8'h00;
    set_data();
    run_byte(4'b0001, 10, gid);
    checks++; if (gid !== 0) begin errors++; $display("FAIL single_grant got=%0d exp=0", gid); end
    req_valid = '0;
    tick();
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b exp=0", tx_done); end
  endtask

  task automatic test_round_robin();
    int gid;
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    do_reset();
    bytes[0] = 8'h10; bytes[1] = 8'h11; bytes[2] = 8'h12; bytes[3] = 8'h13;
    set_data();
    for (int k = 0; k < 5; k++) begin
      run_byte(4'b1111, 2 + k, gid);
      checks++; if (gid !== rr_exp[k]) begin errors++; $display("FAIL rr_order step=%0d got=%0d exp=%0d", k, gid, rr_exp[k]); end
    end
  endtask

  task automatic test_skip();
    int gid;
    run_byte(4'b1001, 3, gid);
    checks++; if (gid !== 3) begin errors++; $display("FAIL skip_first got=%0d exp=3", gid); end
    run_byte(4'b1001, 3, gid);
    checks++; if (gid !== 0) begin errors++; $display("FAIL skip_wrap got=%0d exp=0", gid); end
  endtask

  task automatic test_busy_block();
    int gid;
    req_valid = 4'b0010; tx_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000 || active !== 1'b0) begin errors++; $display("FAIL busy_block cyc=%0d ready=%b active=%b exp 0000/0", k, req_ready, active); end
      tick();
    end
    tx_busy = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL busy_release got=%b exp=0010", req_ready); end
    run_byte(4'b0010, 4, gid);
    checks++; if (gid !== 1) begin errors++; $display("FAIL busy_grant got=%0d exp=1", gid); end
  endtask

  task automatic test_timeout();
    int gid;
    logic [3:0] v;
    for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
    set_data();
    req_valid = 4'b0100; tx_busy = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL to_ready got=%b exp=0100", req_ready); end
    tick();
    checks++; if (tx_begin !== 1'b1 || grant_id !== 3'd2) begin errors++; $display("FAIL to_start begin=%b gid=%0d exp 1/2", tx_begin, grant_id); end
    req_valid = '0;
    tick();
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++; if (timeout_err !== 1'b0 || tx_done !== 1'b0 || active !== 1'b1) begin errors++; $display("FAIL to_early cyc=%0d err=%b done=%b active=%b", k, timeout_err, tx_done, active); end
    end
    tick();
    checks++; if (timeout_err !== 1'b1 || tx_done !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL to_pulse err=%b done=%b active=%b exp 1/0/0", timeout_err, tx_done, active); end
    model_last = 2;
    tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse_width got=%b exp=0", timeout_err); end
    v = 4'($urandom_range(1, 15));
    run_byte(v, 2, gid);
    checks++; if (gid !== rr_model(v, 2)) begin errors++; $display("FAIL to_regrant got=%0d exp=%0d", gid, rr_model(v, 2)); end
  endtask

  task automatic test_reset_mid();
    int gid;
    for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom_range(1, 255));
    set_data();
    req_valid = 4'b1111; tx_busy = 1'b0;
    tick();
    tick();
    tx_busy = 1'b1;
    tick();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL mid_active got=%b exp=1", active); end
    reset = 1'b1;
    tick();
    checks++; if (active !== 1'b0 || tx_begin !== 1'b0 || grant_id !== 3'd0) begin errors++; $display("FAIL mid_reset active=%b begin=%b gid=%0d exp 0/0/0", active, tx_begin, grant_id); end
    checks++; if (tx_done !== 1'b0 || timeout_err !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_regs done=%b err=%b data=%h", tx_done, timeout_err, tx_data); end
    reset = 1'b0; tx_busy = 1'b0;
    model_last = 3;
    run_byte(4'b1111, 3, gid);
    checks++; if (gid !== 0) begin errors++; $display("FAIL mid_first_grant got=%0d exp=0", gid); end
  endtask

  task automatic test_random();
    int gid;
    logic [3:0] v;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
      set_data();
      v = 4'($urandom_range(1, 15));
      run_byte(v, int'($urandom_range(1, 6)), gid);
      req_valid = '0;
      tick();
      checks++; if (tx_done !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rand_idle n=%0d done=%b ready=%b", n, tx_done, req_ready); end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_busy_block();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares the single UART transmitter among up to NUM_REQ byte sources. It accepts one byte per grant over a valid/ready handshake and drives the transmitter's tx_data / tx_begin inputs. It then tracks tx_busy through one complete character before granting again. It sits between the echo/test logic and other byte producers on one side and the uart_top instance on the other.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- START_TIMEOUT, 16: cycles allowed for tx_busy to rise after tx_begin; range 2..255.
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot acceptance; a byte is transferred when req_valid[i] and req_ready[i] are both high.
- tx_data  out  8  byte presented to the transmitter.
- tx_begin  out  1  one-cycle start strobe to the transmitter.
- tx_busy  in  1  transmitter busy flag.
- grant_id  out  3  index of the requester currently owning the transmitter.
- active  out  1  high whenever the state is not IDLE.
- tx_done  out  1  one-cycle pulse when tx_busy falls for the granted byte.
- timeout_err  out  1  one-cycle pulse when tx_busy fails to rise within START_TIMEOUT cycles.

## Operation
- States are IDLE, START, WAIT_BUSY and WAIT_DONE.
- **IDLE:**
  - The winner is the first i with req_valid[i] set, searching from last_grant+1 modulo NUM_REQ.
  - req_ready[winner] is asserted combinationally, only when tx_busy is 0.
  - On the handshake cycle the block registers tx_data ← req_data[winner], grant_id ← winner and last_grant ← winner, then moves to START.
- **START:** tx_begin = 1 for exactly this cycle. Clear timeout_cnt and move to WAIT_BUSY.
- **WAIT_BUSY:**
  - If tx_busy = 1, move to WAIT_DONE.
  - Otherwise, if timeout_cnt == START_TIMEOUT-1, pulse timeout_err and return to IDLE.
  - Otherwise increment timeout_cnt.
- **WAIT_DONE:** when tx_busy = 0, pulse tx_done and return to IDLE.
- **Requester rules:**
  - A requester with no req_valid is skipped; it takes no turn.
  - A requester may drop req_valid at any time before its handshake without error.
- **Other sources on the transmitter:** if tx_busy is high while the block is in IDLE, no grant is issued. This protects against other users of the transmitter.
- **Widths:**
  - timeout_cnt is 8 bits.
  - last_grant and grant_id are 3 bits; the upper unused values are never produced.
  - Round-robin wrap: the search index goes from NUM_REQ-1 back to 0.
- **Reset values:**
  - state = IDLE.
  - last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
  - tx_data = 0, tx_begin = 0, grant_id = 0, active = 0, tx_done = 0, timeout_err = 0, timeout_cnt = 0.
- **Reset mid-operation:** reset in any state returns to IDLE next cycle with the values above. The byte in flight is dropped, and no tx_done or timeout_err is emitted.

## Timing
- The handshake is at cycle T, with the state in IDLE.
- **Cycle T+1:** state is START. tx_begin = 1 and tx_data is valid; tx_data is held stable until the block next leaves IDLE.
- **Cycle T+2:** state is WAIT_BUSY. If tx_busy rises at T+2, the state is WAIT_DONE at T+3.
- **tx_done:** asserted in the cycle after tx_busy is sampled low in WAIT_DONE. The state is IDLE in that same cycle.
- **Next handshake:** possible in the tx_done cycle itself if req_valid is present.
- **Throughput:** the minimum overhead per byte is 3 cycles plus the transmitter busy time.
- **Timeout:** timeout_err is asserted START_TIMEOUT cycles after entry to WAIT_BUSY, and the state is IDLE in that cycle.
- **Exclusivity:** tx_done and timeout_err are never high together. req_ready is 0 outside IDLE.

## Structure
- Package uart_ctrl_pkg holds:
  - the state enum (IDLE, START, WAIT_BUSY, WAIT_DONE);
  - the default NUM_REQ and START_TIMEOUT values;
  - the grant-index width constant.
- One sub-module, rr_arbiter: combinational round-robin pick from req_valid and last_grant.
  - Outputs are the winner index and an any_valid flag.
  - It is reused by later multi-master blocks.
- The FSM, the data register and the timeout counter live in uart_tx_arbiter.

## Test plan
- **Single requester:**
  - Stimulus: after reset, req_valid = 0001 with byte 0x41; the bench model raises tx_busy 1 cycle after tx_begin and holds it for 10 cycles.
  - Required: req_ready[0] at T; tx_begin at T+1 with tx_data = 0x41; tx_done one cycle after busy falls.
- **Round-robin order:**
  - Stimulus: all four valid, with bytes 0x10/0x11/0x12/0x13.
  - Required: grant order 0,1,2,3,0; exactly one tx_begin per tx_done.
- **Skip idle requester:**
  - Stimulus: last_grant = 0 and req_valid = 1001.
  - Required: next grant is 3, then 0.
- **Busy blocking:**
  - Stimulus: tx_busy held high externally in IDLE with req_valid = 0010.
  - Required: req_ready stays 0 until tx_busy falls, then req_ready = 0010 in that cycle.
- **Timeout:**
  - Stimulus: the bench never raises tx_busy.
  - Required: timeout_err pulses 16 cycles after WAIT_BUSY entry; no tx_done; the next valid is granted afterwards.
- **Reset mid-byte:**
  - Stimulus: assert reset during WAIT_DONE.
  - Required: next cycle active = 0, tx_begin = 0 and grant_id = 0; after release with all requesters valid, requester 0 is granted first.
